// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared FSM state type, default latency and bus width macros
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
package dram_ctrl_pkg;
  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/dram_latency_timer.sv
// dram_latency_timer: loadable down-counter with zero flag
module dram_latency_timer
  import dram_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/dram_controller.sv
// dram_controller: single-outstanding DRAM access FSM; DRAM_CTRL_ALIGN_CHECK_EN enables misaligned-address error responses
module dram_controller
  import dram_ctrl_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [`DRAM_ADDRESS_SIZE-1:0] req_addr,
  input  logic [`DRAM_WORD_SIZE-1:0]    req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`DRAM_WORD_SIZE-1:0]    rsp_rdata,
  output logic                          rsp_err,
  output logic [`DRAM_ADDRESS_SIZE-1:0] dram_address,
  inout  wire  [`DRAM_WORD_SIZE-1:0]    dram_data,
  output logic                          dram_wren
);
  state_t state;
  logic we_q, err_q, misaligned, timer_zero;
  logic [`DRAM_WORD_SIZE-1:0] wdata_q;
`ifdef DRAM_CTRL_ALIGN_CHECK_EN
  assign misaligned = |req_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_err = err_q;
  assign dram_wren = state == ACCESS && we_q;
  assign dram_data = dram_wren ? wdata_q : 'z;
  dram_latency_timer u_timer (
    .clock(clock),
    .reset(reset),
    .load (req_valid && req_ready),
    .dec  (state == WAIT),
    .value(CNT_W'(LATENCY - 1)),
    .zero (timer_zero)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      we_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      dram_address <= '0;
    end else case (state)
      IDLE: if (req_valid) begin
        dram_address <= req_addr;
        we_q <= req_we;
        wdata_q <= req_wdata;
        err_q <= misaligned;
        rsp_rdata <= '0;
        state <= misaligned ? RESP : WAIT;
      end
      WAIT: if (timer_zero) state <= ACCESS;
      ACCESS: begin
        rsp_rdata <= we_q ? '0 : dram_data;
        state <= RESP;
      end
      RESP: if (rsp_ready) state <= IDLE;
    endcase
endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller: randomized directed bench against a transaction-level memory model
module tb_dram_controller;
`ifdef DRAM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam int LAT = 4;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, mem_init;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, dram_wren;
  logic [31:0] req_addr, req_wdata, rsp_rdata, dram_address;
  wire  [31:0] dram_data;
  logic u1_req_valid, u1_req_ready, u1_req_we, u1_rsp_valid, u1_rsp_ready, u1_rsp_err, u1_dram_wren;
  logic [31:0] u1_req_addr, u1_req_wdata, u1_rsp_rdata, u1_dram_address;
  wire  [31:0] u1_dram_data;
  logic [31:0] mem [256];
  logic [31:0] model [256];
  int vectors = 0;
  int miscompares = 0;
  dram_controller #(.LATENCY(LAT)) u0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dram_address(dram_address), .dram_data(dram_data),
    .dram_wren(dram_wren)
  );
  dram_controller #(.LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_we(u1_req_we),
    .req_addr(u1_req_addr), .req_wdata(u1_req_wdata), .rsp_valid(u1_rsp_valid), .rsp_ready(u1_rsp_ready),
    .rsp_rdata(u1_rsp_rdata), .rsp_err(u1_rsp_err), .dram_address(u1_dram_address), .dram_data(u1_dram_data),
    .dram_wren(u1_dram_wren)
  );
  // The array drives the bus whenever the controller is not writing
  assign dram_data = dram_wren ? 'z : mem[dram_address[7:0]];
  assign u1_dram_data = u1_dram_wren ? 'z : {u1_dram_address[15:0], 16'hA5A5};
  always @(posedge clock)
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}};
    else if (dram_wren) mem[dram_address[7:0]] <= dram_data;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic run4(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int wren_n, wren_at, rsp_at, exp_rsp, exp_wren;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err = ALIGN_EN && addr[1:0] != 2'b00;
    exp_rd = (we || exp_err) ? 32'h0 : model[addr[7:0]];
    exp_rsp = exp_err ? 1 : LAT + 2;
    exp_wren = (we && !exp_err) ? LAT + 1 : -1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    wren_n = 0; wren_at = -1; rsp_at = -1;
    for (int c = 1; c <= 24; c++) begin
      if (dram_wren) begin
        wren_n++;
        wren_at = c;
        check("wren_data", dram_data, wdata);
      end
      if (rsp_valid) begin
        rsp_at = c;
        break;
      end
      tick();
    end
    check("rsp_cycle", rsp_at, exp_rsp);
    check("wren_pulses", wren_n, exp_wren > 0 ? 1 : 0);
    check("wren_cycle", wren_at, exp_wren);
    if (rsp_at > 0) begin
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_addr", dram_address, addr);
      req_valid = 1'b1; req_addr = $urandom; req_we = 1'($urandom);
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_state", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {1'b1, 1'b0, exp_err, exp_rd});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0; req_valid = 1'b0;
      check("post_handshake", {rsp_valid, req_ready}, 2'b01);
    end
    if (we && !exp_err) model[addr[7:0]] = wdata;
  endtask
  initial begin
    int acc, rsp_n, last, bad, first_rsp;
    for (int i = 0; i < 256; i++) model[i] = {4{8'(i)}};
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    u1_req_valid = 1'b0; u1_req_we = 1'b0; u1_req_addr = '0; u1_req_wdata = '0; u1_rsp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0; mem_init = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_dram_address", dram_address, 0);
    check("rst_dram_wren", dram_wren, 0);
    check("rst_req_ready", req_ready, 1);
    run4(1'b1, 32'h10, 32'hDEADBEEF, 0);
    run4(1'b0, 32'h10, 32'h0, 0);
    check("read_deadbeef", model[8'h10], 32'hDEADBEEF);
    run4(1'b1, 32'h20, 32'h11111111, 0);
    run4(1'b0, 32'h20, 32'h0, 3);
    for (int n = 0; n < 8; n++)
      run4(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, int'($urandom_range(0, 3)));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    check("rst_test_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("after_reset", {req_ready, rsp_valid, dram_wren}, 3'b100);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (dram_wren || rsp_valid) bad++;
      tick();
    end
    check("reset_quiet", bad, 0);
    run4(1'b0, 32'h20, 32'h0, 0);
    run4(1'b0, 32'h13, 32'h0, 1);
    u1_req_valid = 1'b1; u1_rsp_ready = 1'b1;
    acc = 0; rsp_n = 0; last = -1; bad = 0; first_rsp = -1;
    for (int c = 0; c < 40; c++) begin
      u1_req_we = 1'($urandom); u1_req_addr = $urandom & 32'hFFFF_FFFC; u1_req_wdata = $urandom;
      if (u1_req_ready) begin
        if (last >= 0 && c - last != 4) bad++;
        last = c;
        acc++;
      end
      if (u1_rsp_valid) begin
        if (first_rsp < 0) first_rsp = c;
        rsp_n++;
      end
      tick();
    end
    u1_req_valid = 1'b0;
    check("b2b_accepts", acc, 10);
    check("b2b_gaps", bad, 0);
    check("b2b_responses", rsp_n, 10);
    check("b2b_first_rsp", first_rsp, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
